// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 word mux between 16 requesters.
// The winning word is captured and held under a valid/ready handshake.

module mux16_rr_arbiter_mux4 #(
  parameter int W = 32
) (
  input  logic [1:0]   s,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mux16_rr_arbiter #(
  parameter int Length = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       req,
  input  logic [Length-1:0] in0,
  input  logic [Length-1:0] in1,
  input  logic [Length-1:0] in2,
  input  logic [Length-1:0] in3,
  input  logic [Length-1:0] in4,
  input  logic [Length-1:0] in5,
  input  logic [Length-1:0] in6,
  input  logic [Length-1:0] in7,
  input  logic [Length-1:0] in8,
  input  logic [Length-1:0] in9,
  input  logic [Length-1:0] in10,
  input  logic [Length-1:0] in11,
  input  logic [Length-1:0] in12,
  input  logic [Length-1:0] in13,
  input  logic [Length-1:0] in14,
  input  logic [Length-1:0] in15,
  output logic [Length-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       ack,
  output logic [3:0]        sel,
  output logic              busy
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [Length-1:0] data_q, data_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [15:0]       ack_q, ack_d;

  logic [Length-1:0] in_words [16];
  logic [Length-1:0] lvl1_out [4];
  logic [Length-1:0] mux_out;
  logic [31:0]       req_dbl;
  logic [15:0]       req_rot;
  logic [3:0]        win_off;
  logic [3:0]        win_idx;
  logic              win_valid;

  assign in_words[0]  = in0;
  assign in_words[1]  = in1;
  assign in_words[2]  = in2;
  assign in_words[3]  = in3;
  assign in_words[4]  = in4;
  assign in_words[5]  = in5;
  assign in_words[6]  = in6;
  assign in_words[7]  = in7;
  assign in_words[8]  = in8;
  assign in_words[9]  = in9;
  assign in_words[10] = in10;
  assign in_words[11] = in11;
  assign in_words[12] = in12;
  assign in_words[13] = in13;
  assign in_words[14] = in14;
  assign in_words[15] = in15;

  // Rotate requests so bit 0 is the current priority holder, then take the lowest set bit.
  assign req_dbl   = {req, req};
  assign req_rot   = 16'(req_dbl >> ptr_q);
  assign win_valid = |req;
  assign win_idx   = ptr_q + win_off;

  always_comb begin
    win_off = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (req_rot[k]) win_off = 4'(k);
    end
  end

  // Two-level 4:1 tree: select bits [1:0] pick within a group, [3:2] pick the group.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
      mux16_rr_arbiter_mux4 #(.W(Length)) u_mux (
        .s  (win_idx[1:0]),
        .d0 (in_words[4*gi+0]),
        .d1 (in_words[4*gi+1]),
        .d2 (in_words[4*gi+2]),
        .d3 (in_words[4*gi+3]),
        .y  (lvl1_out[gi])
      );
    end
  endgenerate

  mux16_rr_arbiter_mux4 #(.W(Length)) u_mux_lvl2 (
    .s  (win_idx[3:2]),
    .d0 (lvl1_out[0]),
    .d1 (lvl1_out[1]),
    .d2 (lvl1_out[2]),
    .d3 (lvl1_out[3]),
    .y  (mux_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          data_d  = mux_out;
          sel_d   = win_idx;
          ack_d   = 16'd1 << win_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Priority advances only on a completed transfer; 15 wraps to 0 naturally.
        if (out_ready) begin
          ptr_d   = sel_q + 4'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= 4'd0;
      ptr_q   <= 4'd0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_BUSY);
  assign busy      = (state_q == ST_BUSY);
  assign ack       = ack_q;
  assign sel       = sel_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios plus random traffic,
// all checked against a transfer-level round-robin reference model.

module tb_mux16_rr_arbiter;
  localparam int L = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   req;
  logic [L-1:0]  in_w [16];
  logic          out_ready;
  logic [L-1:0]  out_data;
  logic          out_valid;
  logic [15:0]   ack;
  logic [3:0]    sel;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           m_busy;
  int           m_ptr;
  int           m_sel;
  logic [L-1:0] m_data;
  logic [15:0]  m_ack;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.Length(L)) dut (
    .clk(clk), .rst(rst), .req(req),
    .in0(in_w[0]),   .in1(in_w[1]),   .in2(in_w[2]),   .in3(in_w[3]),
    .in4(in_w[4]),   .in5(in_w[5]),   .in6(in_w[6]),   .in7(in_w[7]),
    .in8(in_w[8]),   .in9(in_w[9]),   .in10(in_w[10]), .in11(in_w[11]),
    .in12(in_w[12]), .in13(in_w[13]), .in14(in_w[14]), .in15(in_w[15]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ack(ack), .sel(sel), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // First requester found scanning p, p+1, ... modulo 16.
  function automatic int rr_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  // One clock: sample the inputs the DUT will see, advance model, compare.
  task automatic cycle();
    logic          s_rst;
    logic [15:0]   s_req;
    logic          s_rdy;
    logic [L-1:0]  s_in [16];
    int            w;
    s_rst = rst;
    s_req = req;
    s_rdy = out_ready;
    for (int i = 0; i < 16; i++) s_in[i] = in_w[i];
    @(posedge clk);
    #1;
    m_ack = '0;
    if (s_rst) begin
      m_busy = 0; m_ptr = 0; m_sel = 0; m_data = '0;
    end else if (!m_busy) begin
      w = rr_winner(s_req, m_ptr);
      if (w >= 0) begin
        m_busy = 1;
        m_sel  = w;
        m_data = s_in[w];
        m_ack  = 16'(1 << w);
        $display("grant requester=%0d data=%08h", w, m_data);
      end
    end else if (s_rdy) begin
      m_busy = 0;
      m_ptr  = (m_sel + 1) % 16;
      $display("transfer done requester=%0d data=%08h", m_sel, m_data);
    end
    check("out_valid", 32'(out_valid), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("out_data", out_data, m_data);
    check("sel", 32'(sel), 32'(m_sel));
    check("ack", 32'(ack), 32'(m_ack));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  bit           pend [16];
  int           n_grant;

  initial begin
    rst = 1'b1;
    req = 16'hFFFF;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) in_w[i] = 32'h1000_0000 + 32'(i);

    // Reset with all requesting
    cycle();
    cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single requester
    rst = 1'b0;
    req = 16'h0000;
    out_ready = 1'b1;
    cycle();
    in_w[5] = 32'hDEADBEEF;
    req = 16'h0020;
    cycle();
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_ack", 32'(ack), 32'h0020);
    check("single_sel", 32'(sel), 32'd5);
    req = 16'h0000;
    cycle();
    check("single_valid_drop", 32'(out_valid), 32'd0);
    check("single_ack_drop", 32'(ack), 32'd0);

    // Full round robin from ptr=0
    req = 16'hFFFF;
    do_reset();
    for (int i = 0; i < 16; i++) in_w[i] = 32'(i);
    out_ready = 1'b1;
    n_grant = 0;
    for (int c = 0; c < 36; c++) begin
      cycle();
      if (m_ack != 0) begin
        check("rr_sel", 32'(sel), 32'(n_grant % 16));
        check("rr_data", out_data, 32'(n_grant % 16));
        n_grant++;
      end
    end
    check("rr_grant_count", 32'(n_grant), 32'd18);

    // Wrap and skip
    req = 16'h0000;
    do_reset();
    req = 16'h2000;
    cycle();
    req = 16'h0000;
    cycle();
    req = 16'h0009;
    cycle();
    check("wrap_first", 32'(sel), 32'd0);
    req = 16'h0008;
    cycle();
    cycle();
    check("wrap_second", 32'(sel), 32'd3);
    req = 16'h0000;
    cycle();
    req = 16'h8011;
    cycle();
    check("wrap_ptr4", 32'(sel), 32'd4);
    req = 16'h0000;
    cycle();

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    req = 16'h0080;
    cycle();
    check("bp_sel", 32'(sel), 32'd7);
    req = 16'h0004;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("bp_hold_sel", 32'(sel), 32'd7);
      check("bp_no_ack", 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    cycle();
    check("bp_next", 32'(sel), 32'd2);
    req = 16'h0000;
    cycle();

    // Reset mid-BUSY
    out_ready = 1'b0;
    req = 16'h0100;
    cycle();
    check("mid_sel", 32'(sel), 32'd8);
    req = 16'h0000;
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    req = 16'h8001;
    cycle();
    check("mid_next_winner", 32'(sel), 32'd0);
    req = 16'h8000;
    out_ready = 1'b1;
    cycle();

    // Random traffic obeying the requester contract
    req = 16'h0000;
    do_reset();
    for (int i = 0; i < 16; i++) pend[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (pend[i] && m_ack[i]) begin
          pend[i] = ($urandom_range(0, 3) == 0);
          if (pend[i]) in_w[i] = $urandom;
        end else if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1;
          in_w[i] = $urandom;
        end
        req[i] = pend[i];
      end
      out_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16:1 word multiplexer between 16 requesters and feeds a single registered output channel.
- Each requester presents a request bit and a Length-bit word.
- The block picks one winner and steers the mux select to that winner. It captures the mux output into an output register, acknowledges the winner and presents the word downstream under a valid/ready handshake.
- It sits between 16 producer blocks and one shared consumer, such as a register-file write port or a display/bus driver.

Parameters:
- Length, 32, data width of each requester word and of the output word.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  16  req[i]=1: requester i has a word pending; must hold req[i] and its word stable until ack[i]
- in0..in15  input  Length each  requester words, routed to the shared 16:1 mux inputs
- out_data  output  Length  registered word of current transfer
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data when out_valid&&out_ready at a rising edge
- ack  output  16  one-hot, registered, one-cycle pulse to the winning requester
- sel  output  4  index of last/current winner (registered); debug/steering
- busy  output  1  1 while in BUSY state

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, out_valid=0, out_data=0, ack=0, sel=0, busy=0, priority pointer ptr=0.
  - Reset dominates all other inputs.
- Internal mux:
  - One 16:1 mux of width Length; select = combinational winner index w.
  - Built from the team's existing 4:1 mux tree: S[1:0] drives the first level, S[3:2] the second.
- Winner selection (combinational): w = first i with req[i]=1, searching ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- State IDLE:
  - busy=0, out_valid=0.
  - If req!=0 at an edge: out_data<=mux(w), sel<=w, ack<=onehot(w) for exactly the next cycle, out_valid<=1, state<=BUSY.
  - If req==0: remain IDLE, ack=0.
- State BUSY:
  - busy=1, out_valid=1, out_data and sel held.
  - req is ignored; no further ack pulses.
  - If out_ready=1 at an edge: out_valid<=0, ptr<=(sel+1) mod 16 (15 wraps to 0), state<=IDLE.
  - If out_ready=0: hold indefinitely; out_data and out_valid must not change.
- Latency:
  - req[i] seen at edge N (IDLE) → out_valid=1, ack[i]=1 during cycle N+1.
  - ack is one cycle wide; ack=0 from N+2 onward.
- Throughput: at most one transfer per 2 cycles (BUSY→IDLE→BUSY); there is no back-to-back grant.
- Fairness:
  - ptr moves only on completed transfers.
  - A continuously asserted requester is served within 16 transfers.
  - With all 16 requesting, grants go 0,1,2,…,15,0.
- Requester contract:
  - Requester drops req[i] in or after the cycle ack[i]=1.
  - If req[i] is still high when the block returns to IDLE, it is treated as a new request.
- out_ready while out_valid=0 has no effect.
- Reset mid-BUSY discards the pending word; the winner was already acked and is not re-served.
- No X on outputs after first reset edge. Widths: sel and ptr are 4-bit, and the wrap is natural 4-bit overflow.

Test Plan:
- Reset: rst=1 for 2 cycles with req=16'hFFFF → out_valid=0, ack=0, sel=0, out_data=0, busy=0.
- Single requester:
  - Stimulus: in5=32'hDEADBEEF, req=16'h0020 at edge N, out_ready=1.
  - Cycle N+1: out_valid=1, out_data=32'hDEADBEEF, ack=16'h0020, sel=5.
  - Cycle N+2: out_valid=0, ack=0. ptr becomes 6.
- Full round robin: req=16'hFFFF held, in_i=i, out_ready=1 → sel/out_data sequence 0,1,…,15,0,1, one grant every 2 cycles.
- Wrap and skip: ptr=14 after a grant to 13, req=16'h0009 → winner 0, then 3; ptr ends at 4.
- Backpressure: grant to 7 with out_ready=0 for 5 cycles → out_valid, out_data and sel=7 stable, ack pulsed once only, req[2] raised meanwhile not acked. After out_ready=1, the next grant is 2 on the following IDLE edge.
- Reset mid-BUSY: rst=1 while BUSY with out_ready=0 → out_valid=0, state IDLE, ptr=0 next cycle. With req=16'h8001, the next winner is 0.
